// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key tracker.
// Holds FSM states, scancodes and the tracked-key lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_st_e;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_AA    = 8'hAA;
  localparam logic [7:0] SC_FC    = 8'hFC;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam int NKEYS = 6;

  localparam logic [2:0] K_LEFT  = 3'd0;
  localparam logic [2:0] K_RIGHT = 3'd1;
  localparam logic [2:0] K_UP    = 3'd2;
  localparam logic [2:0] K_SPACE = 3'd3;
  localparam logic [2:0] K_ENTER = 3'd4;
  localparam logic [2:0] K_ESC   = 3'd5;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(
    input logic [7:0] code,
    input logic       ext
  );
    key_hit_t r;
    r = '0;
    unique case (1'b1)
      ext && code == SC_LEFT:   r = '{1'b1, K_LEFT};
      ext && code == SC_RIGHT:  r = '{1'b1, K_RIGHT};
      ext && code == SC_UP:     r = '{1'b1, K_UP};
      !ext && code == SC_SPACE: r = '{1'b1, K_SPACE};
      !ext && code == SC_ENTER: r = '{1'b1, K_ENTER};
      !ext && code == SC_ESC:   r = '{1'b1, K_ESC};
      default:                  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Generic valid/ready bundle: byte stream into the tracker,
// and the key-event push into the event FIFO.
interface ps2_key_tracker_if #(
  parameter int W = 4
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// 4-entry key event FIFO, built only with PS2_EVENT_FIFO_EN.
// Drops pushes when full (sticky overflow) unless a pop frees a slot.
module ps2_event_fifo (
  input  logic                    clk,
  input  logic                    rst_n,
  ps2_key_tracker_if.slave        wr,
  output logic                    ev_valid,
  output logic [3:0]              ev_data,
  input  logic                    ev_ready,
  output logic                    ev_overflow
);
  logic [3:0] mem_q [4];
  logic [3:0] mem_d [4];
  logic [1:0] wp_q, wp_d;
  logic [1:0] rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       full, pop, push_ok;

  assign full     = cnt_q == 3'd4;
  assign ev_valid = cnt_q != 3'd0;
  assign ev_data  = mem_q[rp_q];
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = wr.valid && (!full || pop);
  assign wr.ready = !full || pop;
  assign ev_overflow = ovf_q;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q | (wr.valid && !push_ok);
    if (push_ok) begin
      mem_d[wp_q] = wr.data;
      wp_d        = wp_q + 2'd1;
    end
    if (pop) rp_d = rp_q + 2'd1;
    cnt_d = cnt_q + {2'b0, push_ok} - {2'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: prefix FSM, held-key levels, press pulses.
// Optional event FIFO and ev_* ports when PS2_EVENT_FIFO_EN is defined.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic [NKEYS-1:0] key_state,
  output logic [NKEYS-1:0] key_press,
  output logic             proto_err
`ifdef PS2_EVENT_FIFO_EN
  ,
  output logic             ev_valid,
  output logic [3:0]       ev_data,
  input  logic             ev_ready,
  output logic             ev_overflow
`endif
);
  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES - 1);

  ps2_st_e          st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NKEYS-1:0] ks_q, ks_d;
  logic [NKEYS-1:0] kp_q, kp_d;
  logic             err_q, err_d;
  key_hit_t         lk;
  logic             is_brk;
  logic             ev_push;
  logic [3:0]       ev_word;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ks_d    = ks_q;
    err_d   = err_q;
    lk      = '0;
    is_brk  = 1'b0;
    ev_push = 1'b0;
    if (scan_valid) begin
      cnt_d = '0;
      unique case (1'b1)
        scan_code == SC_E0: begin
          err_d = err_q | (st_q == ST_BRK) | (st_q == ST_EXT_BRK);
          st_d  = ST_EXT;
        end
        scan_code == SC_F0: begin
          if (st_q == ST_IDLE)     st_d  = ST_BRK;
          else if (st_q == ST_EXT) st_d  = ST_EXT_BRK;
          else                     err_d = 1'b1;
        end
        default: begin
          st_d   = ST_IDLE;
          is_brk = (st_q == ST_BRK) || (st_q == ST_EXT_BRK);
          lk     = key_lookup(scan_code,
                     (st_q == ST_EXT) || (st_q == ST_EXT_BRK));
          if (st_q == ST_IDLE &&
              (scan_code == SC_AA || scan_code == SC_FC)) begin
            ks_d = '0;
          end else if (lk.hit) begin
            ks_d[lk.idx] = !is_brk;
            // typematic repeats of a held key are not events
            ev_push = is_brk || !ks_q[lk.idx];
          end
        end
      endcase
    end else if (st_q != ST_IDLE) begin
      if (cnt_q == T_MAX) begin
        st_d  = ST_IDLE;
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    kp_d    = ks_d & ~ks_q;
    ev_word = {is_brk, lk.idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      ks_q  <= '0;
      kp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ks_q  <= ks_d;
      kp_q  <= kp_d;
      err_q <= err_d;
    end
  end

  assign key_state = ks_q;
  assign key_press = kp_q;
  assign proto_err = err_q;

`ifdef PS2_EVENT_FIFO_EN
  ps2_key_tracker_if #(.W(4)) ev_if ();

  assign ev_if.valid = ev_push;
  assign ev_if.data  = ev_word;

  logic unused_rdy;
  assign unused_rdy = ev_if.ready;

  ps2_event_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (ev_if),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_ready    (ev_ready),
    .ev_overflow (ev_overflow)
  );
`else
  logic unused_ev;
  assign unused_ev = ^{ev_push, ev_word};
`endif
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker (TIMEOUT_CYCLES=16).
// Event FIFO scenario is compiled in with PS2_EVENT_FIFO_EN.
module tb_ps2_key_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_tracker_if #(.W(8)) sbus ();

  logic [5:0] key_state, key_press;
  logic       proto_err;
  logic       probe = 1'b0;
  logic       hit = 1'b0;

  typedef struct {
    logic [5:0] ks;
    logic [5:0] kp;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   stray = 0;

`ifdef PS2_EVENT_FIFO_EN
  logic       ev_valid, ev_ready, ev_overflow;
  logic [3:0] ev_data;
  logic [3:0] ev_q[$];
  logic [3:0] ev_e;
  logic       ev_chk = 1'b0;
  int         popped = 0;
`endif

  ps2_key_tracker #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_code   (sbus.data),
    .scan_valid  (sbus.valid),
    .key_state   (key_state),
    .key_press   (key_press),
    .proto_err   (proto_err)
`ifdef PS2_EVENT_FIFO_EN
    ,
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_ready    (ev_ready),
    .ev_overflow (ev_overflow)
`endif
  );

  assign sbus.ready = 1'b1;

  task automatic send(input logic [7:0] c, input logic [5:0] ks,
                      input logic [5:0] kp, input logic er,
                      input string nm);
    @(posedge clk); #1;
    exp_q.push_back('{ks, kp, er, nm});
    sbus.data  = c;
    sbus.valid = 1'b1;
    @(posedge clk); #1;
    sbus.valid = 1'b0;
  endtask

  task automatic look(input logic [5:0] ks, input logic [5:0] kp,
                      input logic er, input string nm);
    @(posedge clk); #1;
    exp_q.push_back('{ks, kp, er, nm});
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  // n idle sampling edges between the previous and the next strobe
  task automatic idle(input int n);
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic check(input logic ok, input string nm,
                       input int got, input int want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  always @(posedge clk) hit <= sbus.valid | probe;

  always @(negedge clk) begin
    if (hit) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: ks=%b kp=%b err=%b",
                 key_state, key_press, proto_err);
      end else begin
        e = exp_q.pop_front();
        if ({key_state, key_press, proto_err} ===
            {e.ks, e.kp, e.err})
          passes++;
        else
          $display("FAIL %s: got ks=%b kp=%b err=%b want ks=%b kp=%b err=%b",
                   e.name, key_state, key_press, proto_err,
                   e.ks, e.kp, e.err);
      end
    end else if (rst_n && key_press != 6'b0) begin
      stray++;
    end
  end

`ifdef PS2_EVENT_FIFO_EN
  always @(negedge clk) begin
    if (ev_chk && ev_valid && ev_ready) begin
      checks++;
      popped++;
      if (ev_q.size() == 0) begin
        $display("FAIL ev_extra: got %h want none", ev_data);
      end else begin
        ev_e = ev_q.pop_front();
        if (ev_data === ev_e) passes++;
        else $display("FAIL ev_data: got %h want %h", ev_data, ev_e);
      end
    end
  end
`endif

  initial begin
    sbus.valid = 1'b0;
    sbus.data  = 8'h00;
`ifdef PS2_EVENT_FIFO_EN
    ev_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    look(6'h00, 6'h00, 1'b0, "reset_state");

    send(8'h29, 6'b001000, 6'b001000, 1'b0, "space_make");
    send(8'hF0, 6'b001000, 6'b000000, 1'b0, "space_f0");
    send(8'h29, 6'b000000, 6'b000000, 1'b0, "space_break");

    send(8'hE0, 6'b000000, 6'b000000, 1'b0, "left_e0");
    send(8'h6B, 6'b000001, 6'b000001, 1'b0, "left_make");
    send(8'hE0, 6'b000001, 6'b000000, 1'b0, "left_e0_rep");
    send(8'h6B, 6'b000001, 6'b000000, 1'b0, "left_repeat");
    send(8'hE0, 6'b000001, 6'b000000, 1'b0, "left_e0_brk");
    send(8'hF0, 6'b000001, 6'b000000, 1'b0, "left_f0");
    send(8'h6B, 6'b000000, 6'b000000, 1'b0, "left_break");

    send(8'h29, 6'b001000, 6'b001000, 1'b0, "hold_space");
    send(8'h76, 6'b101000, 6'b100000, 1'b0, "hold_esc");
    send(8'h29, 6'b101000, 6'b000000, 1'b0, "space_repeat");
    send(8'hAA, 6'b000000, 6'b000000, 1'b0, "bat_clear");

    send(8'hF0, 6'b000000, 6'b000000, 1'b0, "bad_f0");
    send(8'hE0, 6'b000000, 6'b000000, 1'b1, "bad_f0_e0");
    send(8'h74, 6'b000010, 6'b000010, 1'b1, "right_make");
    send(8'hE0, 6'b000010, 6'b000000, 1'b1, "right_e0");
    send(8'hF0, 6'b000010, 6'b000000, 1'b1, "right_f0");
    send(8'h74, 6'b000000, 6'b000000, 1'b1, "right_break");

    pulse_rst();
    look(6'h00, 6'h00, 1'b0, "reset_clears_err");
    send(8'hE0, 6'b000000, 6'b000000, 1'b0, "to_e0");
    idle(20);
    look(6'h00, 6'h00, 1'b1, "timeout_err");
    send(8'h5A, 6'b010000, 6'b010000, 1'b1, "enter_after_to");
    send(8'hE0, 6'b010000, 6'b000000, 1'b1, "ext_e0");
    send(8'h29, 6'b010000, 6'b000000, 1'b1, "ext_space_ign");
    send(8'hFC, 6'b000000, 6'b000000, 1'b1, "fc_clear");

    send(8'hE0, 6'b000000, 6'b000000, 1'b1, "mid_e0");
    pulse_rst();
    look(6'h00, 6'h00, 1'b0, "mid_reset");
    send(8'h74, 6'b000000, 6'b000000, 1'b0, "plain_74_ign");

    send(8'hE0, 6'b000000, 6'b000000, 1'b0, "edge_e0");
    idle(15);
    send(8'h6B, 6'b000001, 6'b000001, 1'b0, "byte_beats_to");
    send(8'hE0, 6'b000001, 6'b000000, 1'b0, "edge_e0b");
    send(8'hF0, 6'b000001, 6'b000000, 1'b0, "edge_f0");
    send(8'h6B, 6'b000000, 6'b000000, 1'b0, "edge_break");
    send(8'hE0, 6'b000000, 6'b000000, 1'b0, "late_e0");
    idle(16);
    send(8'h6B, 6'b000000, 6'b000000, 1'b1, "late_6b_ign");

`ifdef PS2_EVENT_FIFO_EN
    pulse_rst();
    look(6'h00, 6'h00, 1'b0, "fifo_reset");
    ev_ready = 1'b0;
    ev_chk   = 1'b1;
    ev_q.push_back(4'h3);
    ev_q.push_back(4'h4);
    ev_q.push_back(4'h5);
    ev_q.push_back(4'h0);
    send(8'h29, 6'b001000, 6'b001000, 1'b0, "f_space");
    send(8'h5A, 6'b011000, 6'b010000, 1'b0, "f_enter");
    send(8'h76, 6'b111000, 6'b100000, 1'b0, "f_esc");
    send(8'hE0, 6'b111000, 6'b000000, 1'b0, "f_e0a");
    send(8'h6B, 6'b111001, 6'b000001, 1'b0, "f_left");
    send(8'hE0, 6'b111001, 6'b000000, 1'b0, "f_e0b");
    send(8'h74, 6'b111011, 6'b000010, 1'b0, "f_right");
    repeat (2) @(posedge clk);
    #1;
    check(ev_overflow === 1'b1, "ev_overflow", int'(ev_overflow), 1);
    ev_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check(popped == 4, "ev_drain_count", popped, 4);
    check(ev_valid === 1'b0, "ev_empty", int'(ev_valid), 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "pending_expect", exp_q.size(), 0);
    check(stray == 0, "stray_press", stray, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, SHALL set the maximum clk cycles allowed between a prefix byte (E0/F0) and its follow-up byte.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 scan_code  input  8  latest received PS/2 set-2 byte (receiver key[7:0]).
REQ-005 scan_valid  input  1  one-cycle strobe: scan_code is new (receiver new_event).
REQ-006 key_state  output  6  level per tracked key, 1 = held; index 0 LEFT (E0 6B), 1 RIGHT (E0 74), 2 UP (E0 75), 3 SPACE (29), 4 ENTER (5A), 5 ESC (76).
REQ-007 key_press  output  6  one-cycle pulse on a 0->1 transition of the matching key_state bit.
REQ-008 proto_err  output  1  sticky flag: a prefix timeout or an unexpected prefix sequence has occurred.

Function
REQ-009 FSM states SHALL be IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-010 Byte E0 SHALL move any state to EXT; from BRK or EXT_BRK it SHALL also set proto_err.
REQ-011 Byte F0 SHALL move IDLE->BRK and EXT->EXT_BRK; in BRK or EXT_BRK it SHALL hold the state and set proto_err.
REQ-012 Any other byte SHALL return the FSM to IDLE and be decoded: IDLE = make, BRK = break, EXT = extended make, EXT_BRK = extended break.
REQ-013 A make SHALL set the matching key_state bit; a break SHALL clear it; codes not in REQ-006, or non-extended codes received in EXT/EXT_BRK, SHALL be ignored.
REQ-014 key_state SHALL update, and key_press SHALL pulse, in the cycle after the scan_valid that carries the final byte (latency 1).
REQ-015 A make for a key already held (typematic repeat) SHALL NOT pulse key_press.
REQ-016 Byte AA or FC received in IDLE SHALL clear all key_state bits with no key_press pulse.
REQ-017 A timeout counter SHALL reset on every scan_valid and count while the FSM is not IDLE; on reaching TIMEOUT_CYCLES-1 the FSM SHALL return to IDLE and proto_err SHALL set.
REQ-018 scan_valid coinciding with timeout expiry: the byte SHALL take priority and the timeout SHALL be discarded.
REQ-019 The counter width SHALL be clog2(TIMEOUT_CYCLES) and SHALL NOT wrap.

Reset
REQ-020 rst_n low SHALL asynchronously force FSM=IDLE, counter=0, key_state=0, key_press=0, proto_err=0; deassertion SHALL be synchronous to clk.
REQ-021 A reset in the middle of a multi-byte sequence SHALL discard the partial sequence; the next byte SHALL be decoded from IDLE.

Configuration
REQ-022 Macro PS2_EVENT_FIFO_EN defined: ports ev_valid (out,1), ev_data (out,4 = {break,key index[2:0]}), ev_ready (in,1) and ev_overflow (out,1, sticky) SHALL exist; every decoded make/break of a tracked key (typematic repeats excluded) SHALL be pushed into a 4-entry FIFO; pop on ev_valid&&ev_ready; push when full SHALL be dropped and set ev_overflow; simultaneous push and pop when full SHALL succeed.
REQ-023 Macro undefined: these ports and the FIFO SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 Package ps2_pkg SHALL hold the FSM state typedef, scancode constants (E0, F0, AA, FC, tracked codes) and key index constants.
REQ-025 The FIFO SHALL be the sub-module ps2_event_fifo, instantiated only under PS2_EVENT_FIFO_EN.

Verification
REQ-026 Bytes 29 then F0 29 -> key_state[3]=1 one cycle after the first strobe with key_press[3] pulsing once; key_state[3]=0 one cycle after the 29 that follows F0.
REQ-027 Bytes E0 6B, E0 6B, E0 F0 6B -> key_state[0] set once, a single key_press[0] pulse, then cleared.
REQ-028 Byte E0, then no strobe for TIMEOUT_CYCLES (parameter overridden to 16) -> FSM returns to IDLE and proto_err=1; next 5A -> key_state[4]=1.
REQ-029 Hold 29 and 76, then byte AA -> key_state=0 with no key_press pulse.
REQ-030 E0 then rst_n pulsed low, then 74 -> key_state[1] stays 0 (non-extended 74 ignored).
REQ-031 FIFO build, ev_ready=0, five makes of distinct keys -> four entries retained in order, ev_overflow=1; then ev_ready=1 drains exactly four entries.
